// File: rtl/uc_multiciclo.sv
// Multicycle CPU control unit: 12-state FSM that sequences fetch, decode and the
// per-opcode execute steps, producing datapath strobes for the current state.
// Latency: strobes are combinational from the current state, so they are valid in the same cycle.
// Backpressure: FETCH, MEMRD and MEMWR stall on mem_ready; rst_n low forces every strobe to 0 asynchronously.
//
// Ports:
//   clk, rst_n         - clock (rising edge) and asynchronous active-low reset
//   inscod[5:0]        - opcode field of the instruction register (sampled in DECODE)
//   zero               - ALU zero flag (conditions PCWrite in BRANCH)
//   mem_ready          - memory access completes in the cycle it is high
//   RegDist..illegal   - 1-bit datapath strobes
//   ALUop, ALUsrcB, PCsrc - multi-bit datapath selects
//   state[3:0]         - current state code
module uc_multiciclo (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] inscod,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       RegDist,
  output logic       Branch,
  output logic       MemRead,
  output logic       Memtoreg,
  output logic       MemWrite,
  output logic       ALUsrc,
  output logic       Regwrite,
  output logic       IRWrite,
  output logic       PCWrite,
  output logic       IorD,
  output logic       instr_done,
  output logic       illegal,
  output logic [2:0] ALUop,
  output logic [1:0] ALUsrcB,
  output logic [1:0] PCsrc,
  output logic [3:0] state
);

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC   = 4'd6,
    S_RWB    = 4'd7,
    S_BRANCH = 4'd8,
    S_ADDIEX = 4'd9,
    S_ADDIWB = 4'd10,
    S_JUMP   = 4'd11
  } state_e;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  state_e     state_q, state_d;
  logic [5:0] opcode_q, opcode_d;

  // Next-state logic. The opcode is captured as DECODE is left, so later
  // decisions are immune to the instruction register changing underneath us.
  always_comb begin
    state_d  = S_FETCH;
    opcode_d = opcode_q;
    case (state_q)
      S_FETCH:  state_d = mem_ready ? S_DECODE : S_FETCH;
      S_DECODE: begin
        opcode_d = inscod;
        case (inscod)
          OP_RTYPE: state_d = S_EXEC;
          OP_LW:    state_d = S_MEMADR;
          OP_SW:    state_d = S_MEMADR;
          OP_BEQ:   state_d = S_BRANCH;
          OP_ADDI:  state_d = S_ADDIEX;
          OP_J:     state_d = S_JUMP;
          default:  state_d = S_FETCH;
        endcase
      end
      S_MEMADR: state_d = (opcode_q == OP_LW) ? S_MEMRD : S_MEMWR;
      S_MEMRD:  state_d = mem_ready ? S_MEMWB : S_MEMRD;
      S_MEMWR:  state_d = mem_ready ? S_FETCH : S_MEMWR;
      S_EXEC:   state_d = S_RWB;
      S_ADDIEX: state_d = S_ADDIWB;
      default:  state_d = S_FETCH;  // terminal states and unused codes 12-15
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_FETCH;
      opcode_q <= 6'b000000;
    end else begin
      state_q  <= state_d;
      opcode_q <= opcode_d;
    end
  end

  // Strobes are decoded combinationally: IRWrite/PCWrite must follow mem_ready
  // and zero within the same cycle, and reset has to kill them without a clock.
  always_comb begin
    RegDist    = 1'b0;
    Branch     = 1'b0;
    MemRead    = 1'b0;
    Memtoreg   = 1'b0;
    MemWrite   = 1'b0;
    ALUsrc     = 1'b0;
    Regwrite   = 1'b0;
    IRWrite    = 1'b0;
    PCWrite    = 1'b0;
    IorD       = 1'b0;
    instr_done = 1'b0;
    illegal    = 1'b0;
    ALUop      = 3'b000;
    ALUsrcB    = 2'b00;
    PCsrc      = 2'b00;
    case (state_q)
      S_FETCH: begin
        MemRead = 1'b1;
        ALUsrcB = 2'b01;
        IRWrite = mem_ready;
        PCWrite = mem_ready;
      end
      S_DECODE: begin
        ALUsrcB = 2'b11;
        illegal = !(inscod == OP_RTYPE || inscod == OP_LW || inscod == OP_SW ||
                    inscod == OP_BEQ || inscod == OP_ADDI || inscod == OP_J);
      end
      S_MEMADR: begin
        ALUsrc  = 1'b1;
        ALUsrcB = 2'b10;
      end
      S_MEMRD: begin
        MemRead = 1'b1;
        IorD    = 1'b1;
      end
      S_MEMWB: begin
        Regwrite   = 1'b1;
        Memtoreg   = 1'b1;
        instr_done = 1'b1;
      end
      S_MEMWR: begin
        MemWrite   = 1'b1;
        IorD       = 1'b1;
        instr_done = mem_ready;
      end
      S_EXEC: begin
        ALUsrc = 1'b1;
        ALUop  = 3'b111;
      end
      S_RWB: begin
        RegDist    = 1'b1;
        Regwrite   = 1'b1;
        instr_done = 1'b1;
      end
      S_BRANCH: begin
        ALUsrc     = 1'b1;
        ALUop      = 3'b001;
        Branch     = 1'b1;
        PCsrc      = 2'b01;
        PCWrite    = zero;
        instr_done = 1'b1;
      end
      S_ADDIEX: begin
        ALUsrc  = 1'b1;
        ALUsrcB = 2'b10;
      end
      S_ADDIWB: begin
        Regwrite   = 1'b1;
        instr_done = 1'b1;
      end
      S_JUMP: begin
        PCWrite    = 1'b1;
        PCsrc      = 2'b10;
        instr_done = 1'b1;
      end
      default: ;
    endcase
    // Reset overrides whatever the state decode produced.
    if (!rst_n) begin
      RegDist    = 1'b0;
      Branch     = 1'b0;
      MemRead    = 1'b0;
      Memtoreg   = 1'b0;
      MemWrite   = 1'b0;
      ALUsrc     = 1'b0;
      Regwrite   = 1'b0;
      IRWrite    = 1'b0;
      PCWrite    = 1'b0;
      IorD       = 1'b0;
      instr_done = 1'b0;
      illegal    = 1'b0;
      ALUop      = 3'b000;
      ALUsrcB    = 2'b00;
      PCsrc      = 2'b00;
    end
  end

  assign state = state_q;

endmodule

// File: doc/uc_multiciclo.md
UC_MULTICICLO -- requirements
Module: uc_multiciclo

Interface
REQ-001 SHALL have port clk  in  1  single system clock; all state changes occur on its rising edge.
REQ-002 SHALL have port rst_n  in  1  asynchronous, active-low reset.
REQ-003 SHALL have port inscod  in  6  opcode field of the instruction register.
REQ-004 SHALL have port zero  in  1  ALU zero flag.
REQ-005 SHALL have port mem_ready  in  1  memory access completes in the cycle it is high.
REQ-006 SHALL have 1-bit output ports RegDist, Branch, MemRead, Memtoreg, MemWrite, ALUsrc, Regwrite, IRWrite, PCWrite, IorD, instr_done and illegal.
REQ-007 SHALL have output ports ALUop (3 bits), ALUsrcB (2 bits), PCsrc (2 bits) and state (4 bits, current state code).
REQ-008 SHALL drive ALUsrc as the ALU A-operand select: 0 = PC, 1 = register A.
REQ-009 SHALL encode ALUsrcB as 00 = reg B, 01 = constant 4, 10 = sign-extended immediate, 11 = immediate<<2.
REQ-010 SHALL encode ALUop as 000 = add, 001 = sub, 111 = R-type funct decode.
REQ-011 SHALL encode PCsrc as 00 = ALU result, 01 = ALUOut register, 10 = jump target.

Function
REQ-012 SHALL be a multicycle control FSM with states FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXEC=6, RWB=7, BRANCH=8, ADDIEX=9, ADDIWB=10, JUMP=11; codes 12-15 SHALL go to FETCH on the next edge.
REQ-013 Any output not listed for a state SHALL be 0 in that state.
REQ-014 FETCH: MemRead=1, IorD=0, ALUsrc=0, ALUsrcB=01, ALUop=000, PCsrc=00.
REQ-015 FETCH: IRWrite=PCWrite=mem_ready.
REQ-016 FETCH SHALL hold while mem_ready=0 and go to DECODE when mem_ready=1.
REQ-017 DECODE: ALUsrc=0, ALUsrcB=11, ALUop=000.
REQ-018 DECODE next state by inscod: 000000->EXEC, 100011->MEMADR, 101011->MEMADR, 000100->BRANCH, 001000->ADDIEX, 000010->JUMP.
REQ-019 DECODE with any other inscod: illegal=1 for that cycle and next state FETCH.
REQ-020 MEMADR: ALUsrc=1, ALUsrcB=10, ALUop=000; next state MEMRD if the latched opcode is 100011, otherwise MEMWR.
REQ-021 The opcode SHALL be latched internally on leaving DECODE and SHALL be the only opcode used for decisions after DECODE.
REQ-022 MEMRD: MemRead=1, IorD=1; SHALL hold until mem_ready=1, then go to MEMWB.
REQ-023 MEMWB: Regwrite=1, Memtoreg=1, RegDist=0, instr_done=1; next state FETCH.
REQ-024 MEMWR: MemWrite=1, IorD=1; SHALL hold until mem_ready=1, then go to FETCH with instr_done=1 in the completing cycle.
REQ-025 EXEC: ALUsrc=1, ALUsrcB=00, ALUop=111; next state RWB.
REQ-026 RWB: RegDist=1, Regwrite=1, Memtoreg=0, instr_done=1; next state FETCH.
REQ-027 BRANCH: ALUsrc=1, ALUsrcB=00, ALUop=001, Branch=1, PCsrc=01, PCWrite=zero, instr_done=1; next state FETCH.
REQ-028 ADDIEX: ALUsrc=1, ALUsrcB=10, ALUop=000; next state ADDIWB.
REQ-029 ADDIWB: RegDist=0, Regwrite=1, instr_done=1; next state FETCH.
REQ-030 JUMP: PCWrite=1, PCsrc=10, instr_done=1; next state FETCH.
REQ-031 MemRead and MemWrite SHALL never be high in the same cycle.
REQ-032 Regwrite and MemWrite SHALL never be high in the same cycle.
REQ-033 Latency (mem_ready tied 1): R-type/addi/lw = 4/4/5 cycles; sw/beq/j = 4/3/3 cycles.
REQ-034 Each memory wait cycle SHALL add exactly one cycle to the latency of REQ-033.

Reset
REQ-035 While rst_n=0, state SHALL be FETCH (0), the latched opcode SHALL be 000000, and every output except state SHALL be 0, gated regardless of state.
REQ-036 Assertion of rst_n mid-instruction (e.g. in MEMWR) SHALL immediately deassert all strobes without waiting for clk.
REQ-037 On the first clk edge after rst_n rises, the FSM SHALL operate in FETCH per REQ-014 to REQ-016.

Verification
REQ-038 Reset, release, mem_ready=1, inscod=000000 -> states 0,1,6,7,0; ALUop=111 in EXEC; RegDist=1, Regwrite=1 in RWB.
REQ-039 lw (100011) with mem_ready=0 for 2 cycles in MEMRD -> states 0,1,2,3,3,3,4,0; Memtoreg=1 and Regwrite=1 only in MEMWB.
REQ-040 beq (000100) with zero=1, then with zero=0 -> PCWrite=1 vs 0 in state 8, PCsrc=01, ALUop=001 in both runs.
REQ-041 inscod=111111 -> illegal=1 for one cycle in DECODE, next state 0, no Regwrite or MemWrite asserted.
REQ-042 sw (101011), rst_n pulled low while in MEMWR -> MemWrite falls asynchronously, state=0; a subsequent j (000010) -> PCWrite=1, PCsrc=10 in state 11.
REQ-043 FETCH with mem_ready=0 for 3 cycles -> IRWrite=PCWrite=0 and state stays 0 for those cycles; both go to 1 only in the cycle mem_ready=1.
